// File: rtl/eu_dispatch.sv
// eu_dispatch: holds one decoded instruction and writes it into a single capable, non-full
// EU instruction queue, picked round-robin. Dispatch from the holding register takes zero cycles.
module eu_dispatch #(
  parameter int NUM_EUS     = 4,
  parameter int STALL_CNT_W = 8,
  parameter int ENTRY_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic [ENTRY_W-1:0]     instr_i,
  input  logic [NUM_EUS-1:0]     instr_eu_mask_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [NUM_EUS-1:0]     iqueue_full_i,
  output logic [ENTRY_W-1:0]     dispatched_instr_o,
  output logic [NUM_EUS-1:0]     dispatched_instr_valid_o,
  output logic                   bad_mask_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);
  localparam int PW = $clog2(NUM_EUS);
  logic                   hold_valid_q, hold_valid_d;
  logic [ENTRY_W-1:0]     hold_instr_q;
  logic [NUM_EUS-1:0]     hold_mask_q;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NUM_EUS-1:0]     elig;
  logic [PW-1:0]          idx, gidx;
  logic                   found, drop, stall, load;
  // Rotating priority search: first eligible EU at or after rr_ptr_q wins.
  always_comb begin
    elig = (hold_valid_q && !flush_i) ? hold_mask_q & ~iqueue_full_i : '0;
    found = 1'b0;
    gidx = rr_ptr_q;
    idx = '0;
    for (int i = 0; i < NUM_EUS; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NUM_EUS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx = idx;
      end
    end
  end
  assign dispatched_instr_valid_o = found ? NUM_EUS'(1) << gidx : '0;
  assign dispatched_instr_o = hold_instr_q;
  assign drop = hold_valid_q && hold_mask_q == '0 && !flush_i;
  assign stall = hold_valid_q && hold_mask_q != '0 && !found && !flush_i;
  assign bad_mask_o = drop;
  assign stall_cycles_o = stall_cnt_q;
  // Upstream is flushed alongside us, so readiness is reported during flush too.
  assign instr_ready_o = !hold_valid_q || found || drop || flush_i;
  assign load = instr_valid_i && instr_ready_o && !flush_i;
  assign hold_valid_d = load ? 1'b1 : (found || drop || flush_i) ? 1'b0 : hold_valid_q;
  assign rr_ptr_d = !found ? rr_ptr_q : gidx == PW'(NUM_EUS - 1) ? '0 : gidx + 1'b1;
  assign stall_cnt_d = !stall ? '0 : &stall_cnt_q ? stall_cnt_q : stall_cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_mask_q  <= '0;
      rr_ptr_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      stall_cnt_q  <= stall_cnt_d;
      if (load) begin
        hold_instr_q <= instr_i;
        hold_mask_q  <= instr_eu_mask_i;
      end
    end
  end
endmodule
